// File: rtl/rs232_recv_fifo.sv
// ============================================================================
// rs232_recv_fifo : RS-232 receiver, DATA_BITS words into a FIFO, valid/ready.
// Optional parity via RS232_RECV_PARITY_EN. Rev 1.0
// ============================================================================
`default_nettype none

module rs232_recv_fifo #(
  parameter int PERIOD     = 1250,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] c_HALF  = CNT_W'(PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] c_FULL  = CNT_W'(PERIOD - 1);
  localparam logic [BIT_W-1:0] c_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [PTR_W:0]   c_DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [BIT_W-1:0]     r_bit, w_bit_nxt;
  logic                 w_tick;
  logic                 w_push, w_ferr, w_perr;
  logic                 r_push;
  logic                 r_frame_err;
  logic                 r_overrun;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick = (r_cnt == '0);

`ifdef RS232_RECV_PARITY_EN
  logic r_perr, w_perr_nxt;
  logic r_parity_err;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_bit       <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef RS232_RECV_PARITY_EN
      r_perr       <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_bit       <= w_bit_nxt;
      r_push      <= w_push;
      r_frame_err <= w_ferr;
`ifdef RS232_RECV_PARITY_EN
      r_perr       <= w_perr_nxt;
      r_parity_err <= w_perr;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_tick ? r_cnt : r_cnt - 1'b1;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    w_perr      = 1'b0;
`ifdef RS232_RECV_PARITY_EN
    w_perr_nxt  = r_perr;
`endif
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_cnt_nxt   = c_HALF;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_rx_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt   = c_FULL;
            w_bit_nxt   = '0;
            w_state_nxt = S_DATA;
`ifdef RS232_RECV_PARITY_EN
            w_perr_nxt  = 1'b0;
`endif
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
          w_cnt_nxt   = c_FULL;
          w_bit_nxt   = r_bit + 1'b1;
          if (r_bit == c_LAST) begin
`ifdef RS232_RECV_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef RS232_RECV_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          // Data XOR parity bit must equal 1 for odd sense, 0 for even.
          w_perr_nxt  = ((^r_shift) ^ r_rx_s) != 1'(PARITY_ODD);
          w_cnt_nxt   = c_FULL;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          if (r_rx_s) begin
`ifdef RS232_RECV_PARITY_EN
            w_perr = r_perr;
            w_push = !r_perr;
`else
            w_push = 1'b1;
`endif
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO: r_shift stays stable for half a bit after the stop tick, so the
  // registered push can write it directly.
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]       r_fill;
  logic                 w_full, w_pop, w_wr;

  assign w_full = (r_fill == c_DEPTH);
  assign w_pop  = (r_fill != '0) && rx_ready;
  assign w_wr   = r_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_fill    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_push && w_full && !w_pop;
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_pop)      r_fill <= r_fill + 1'b1;
      else if (!w_wr && w_pop) r_fill <= r_fill - 1'b1;
    end
  end

  assign rx_data   = r_mem[r_rd_ptr];
  assign rx_valid  = (r_fill != '0);
  assign fill      = r_fill;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
`ifdef RS232_RECV_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire
